// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word/opcode types, HALT opcode, fetch FSM states and PC step
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [5:0] opcode_t;
  typedef enum logic {RUN, HALTED} fetch_state_t;
  localparam opcode_t HALT = 6'b111111;
  localparam word_t PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: icache handshake, hazard/redirect inputs and IF/ID outputs of the fetch stage
interface fetch_stage_if #(parameter int CNT_W = 32);
  import cpu_types_pkg::*;
  logic ihit;
  word_t iload;
  logic imemREN;
  word_t imemaddr;
  logic stall;
  logic redirect_valid;
  word_t redirect_pc;
  word_t inst_out;
  word_t pc_next_out;
  logic valid_out;
  logic halted;
  logic [CNT_W-1:0] fetch_count;
  modport master (
    input ihit, iload, stall, redirect_valid, redirect_pc,
    output imemREN, imemaddr, inst_out, pc_next_out, valid_out, halted, fetch_count
  );
  modport slave (
    output ihit, iload, stall, redirect_valid, redirect_pc,
    input imemREN, imemaddr, inst_out, pc_next_out, valid_out, halted, fetch_count
  );
endinterface

// File: rtl/ifid_latch.sv
// ifid_latch: IF/ID register; flush beats enable, enabled cycles load an instruction or a bubble
module ifid_latch
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  i_en,
  input  logic  i_flush,
  input  logic  i_load,
  input  word_t i_inst,
  input  word_t i_pc_next,
  output word_t o_inst,
  output word_t o_pc_next,
  output logic  o_valid
);
  word_t r_inst, r_pc_next;
  logic r_valid;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_inst    <= '0;
      r_pc_next <= '0;
      r_valid   <= 1'b0;
    end else if (i_flush) begin
      r_inst    <= '0;
      r_pc_next <= '0;
      r_valid   <= 1'b0;
    end else if (i_en) begin
      r_inst    <= i_load ? i_inst : '0;
      r_pc_next <= i_load ? i_pc_next : '0;
      r_valid   <= i_load;
    end
  end
  assign o_inst    = r_inst;
  assign o_pc_next = r_pc_next;
  assign o_valid   = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, RUN/HALTED FSM, icache request, redirect/flush and fetched-instruction counter
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000,
  parameter int    CNT_W   = 32
) (
  input logic CLK,
  input logic nRST,
  fetch_stage_if.master fs
);
  fetch_state_t r_state, w_state_next;
  word_t r_pc, w_pc_next, w_pc_plus;
  logic [CNT_W-1:0] r_cnt;
  logic w_run, w_is_halt, w_accept;
  assign w_run     = (r_state == RUN);
  assign w_pc_plus = r_pc + PC_STEP;
  assign w_is_halt = (fs.iload[31:26] == HALT);
  // redirect wins over stall, stall wins over a hit; HALTED ignores ihit
  assign w_accept  = w_run & ~fs.redirect_valid & ~fs.stall & fs.ihit;
  always_comb begin
    w_pc_next    = fs.redirect_valid ? fs.redirect_pc :
                   (w_accept && !w_is_halt) ? w_pc_plus : r_pc;
    w_state_next = fs.redirect_valid ? RUN :
                   (w_accept && w_is_halt) ? HALTED : r_state;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
      r_pc    <= PC_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_cnt   <= (w_accept && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
    end
  end
  ifid_latch u_ifid (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_en      (~fs.stall),
    .i_flush   (fs.redirect_valid),
    .i_load    (w_run & fs.ihit),
    .i_inst    (fs.iload),
    .i_pc_next (w_pc_plus),
    .o_inst    (fs.inst_out),
    .o_pc_next (fs.pc_next_out),
    .o_valid   (fs.valid_out)
  );
  assign fs.imemaddr    = r_pc;
  assign fs.imemREN     = w_run;
  assign fs.halted      = ~w_run;
  assign fs.fetch_count = r_cnt;
endmodule
